// File: rtl/dma_cfg_sequencer.sv
// AXI4-Lite master that programs one register-mode DMA transfer (SRC, DST, LEN, GO) and polls STATUS.DONE.
// Optional feature macro: DMA_SEQ_TIMEOUT_EN bounds the number of STATUS reads to TIMEOUT.
module dma_cfg_sequencer #(
   parameter int unsigned        ADDR_W    = 32,
   parameter int unsigned        DATA_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int unsigned        POLL_GAP  = 16,
   parameter int unsigned        TIMEOUT   = 1024
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [DATA_W-1:0]   cmd_src,
   input  logic [DATA_W-1:0]   cmd_dst,
   input  logic [DATA_W-1:0]   cmd_len,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [2:0]          m_axi_awprot,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic [2:0]          m_axi_arprot,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_SRC, S_WR_DST, S_WR_LEN, S_WR_GO,
      S_POLL_WAIT, S_POLL_RD, S_DONE, S_ERR
   } state_e;

   localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic                aw_acc_q, aw_acc_d, w_acc_q, w_acc_d, ar_acc_q, ar_acc_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [1:0]          err_code_q, err_code_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                in_wr, b_hs, r_hs;
   logic                unused_ok;

`ifdef DMA_SEQ_TIMEOUT_EN
   localparam int unsigned PC_W = $clog2(TIMEOUT + 1);
   logic [PC_W-1:0]     polls_q, polls_d, polls_inc;
   assign polls_inc = (polls_q == PC_W'(TIMEOUT)) ? polls_q : polls_q + PC_W'(1);
`endif

   assign in_wr = (state_q == S_WR_SRC) || (state_q == S_WR_DST) ||
                  (state_q == S_WR_LEN) || (state_q == S_WR_GO);

   // B/R readiness follows acceptance of the request channel(s) of the current access.
   assign m_axi_bready  = in_wr && aw_acc_q && w_acc_q;
   assign m_axi_rready  = (state_q == S_POLL_RD) && ar_acc_q;
   assign b_hs          = m_axi_bready && m_axi_bvalid;
   assign r_hs          = m_axi_rready && m_axi_rvalid;

   assign cmd_ready     = (state_q == S_IDLE);
   assign busy          = in_wr || (state_q == S_POLL_WAIT) || (state_q == S_POLL_RD);
   assign done          = (state_q == S_DONE);
   assign err           = err_q;
   assign err_code      = err_code_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = '0;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = '0;
   assign m_axi_arvalid = arvalid_q;
   assign unused_ok     = ^{m_axi_rdata[DATA_W-1:1], TIMEOUT};

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      arvalid_d  = arvalid_q;
      aw_acc_d   = aw_acc_q;
      w_acc_d    = w_acc_q;
      ar_acc_d   = ar_acc_q;
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      gap_d      = gap_q;
`ifdef DMA_SEQ_TIMEOUT_EN
      polls_d    = polls_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               src_d      = cmd_src;
               dst_d      = cmd_dst;
               len_d      = cmd_len;
               err_d      = 1'b0;
               err_code_d = 2'b00;
               state_d    = S_WR_SRC;
            end
         end
         S_WR_SRC, S_WR_DST, S_WR_LEN, S_WR_GO: begin
            if (awvalid_q && m_axi_awready) begin
               awvalid_d = 1'b0;
               aw_acc_d  = 1'b1;
            end
            if (wvalid_q && m_axi_wready) begin
               wvalid_d = 1'b0;
               w_acc_d  = 1'b1;
            end
            if (b_hs) begin
               if (m_axi_bresp != 2'b00) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
                  state_d    = S_ERR;
               end else begin
                  case (state_q)
                     S_WR_SRC: state_d = S_WR_DST;
                     S_WR_DST: state_d = S_WR_LEN;
                     S_WR_LEN: state_d = S_WR_GO;
                     default: begin
                        state_d = S_POLL_WAIT;
`ifdef DMA_SEQ_TIMEOUT_EN
                        polls_d = '0;
`endif
                     end
                  endcase
               end
            end
         end
         S_POLL_WAIT: begin
            if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL_RD;
            else                               gap_d   = gap_q + GAP_W'(1);
         end
         S_POLL_RD: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               ar_acc_d  = 1'b1;
            end
            if (r_hs) begin
`ifdef DMA_SEQ_TIMEOUT_EN
               polls_d = polls_inc;
`endif
               if (m_axi_rresp != 2'b00) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b10;
                  state_d    = S_ERR;
               end else if (m_axi_rdata[0]) begin
                  state_d = S_DONE;
`ifdef DMA_SEQ_TIMEOUT_EN
               end else if (polls_inc == PC_W'(TIMEOUT)) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b11;
                  state_d    = S_ERR;
`endif
               end else begin
                  state_d = S_POLL_WAIT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // State-entry actions: load the next access payload when the state changes.
      if (state_d != state_q) begin
         case (state_d)
            S_WR_SRC: begin
               awaddr_d = BASE_ADDR;
               wdata_d  = src_d;
            end
            S_WR_DST: begin
               awaddr_d = BASE_ADDR + ADDR_W'(4);
               wdata_d  = dst_q;
            end
            S_WR_LEN: begin
               awaddr_d = BASE_ADDR + ADDR_W'(8);
               wdata_d  = len_q;
            end
            S_WR_GO: begin
               awaddr_d = BASE_ADDR + ADDR_W'(12);
               wdata_d  = DATA_W'(1);
            end
            S_POLL_WAIT: gap_d = '0;
            S_POLL_RD: begin
               arvalid_d = 1'b1;
               ar_acc_d  = 1'b0;
               araddr_d  = BASE_ADDR + ADDR_W'(12);
            end
            default: ;
         endcase
         if ((state_d == S_WR_SRC) || (state_d == S_WR_DST) ||
             (state_d == S_WR_LEN) || (state_d == S_WR_GO)) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_acc_d  = 1'b0;
            w_acc_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         aw_acc_q   <= 1'b0;
         w_acc_q    <= 1'b0;
         ar_acc_q   <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
         gap_q      <= '0;
`ifdef DMA_SEQ_TIMEOUT_EN
         polls_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         arvalid_q  <= arvalid_d;
         aw_acc_q   <= aw_acc_d;
         w_acc_q    <= w_acc_d;
         ar_acc_q   <= ar_acc_d;
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         gap_q      <= gap_d;
`ifdef DMA_SEQ_TIMEOUT_EN
         polls_q    <= polls_d;
`endif
      end
   end

endmodule

// File: tb/tb_dma_cfg_sequencer.sv
// Directed bench for dma_cfg_sequencer: a configurable AXI4-Lite slave plus a transaction-level model
// of the expected register writes, STATUS reads and completion status, checked every cycle.
`timescale 1ns/1ps
module tb_dma_cfg_sequencer;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int unsigned GAP  = 3;
   localparam int unsigned TMO  = 4;

   logic        ACLK = 1'b0, ARESETN = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [31:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
   logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
   logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
   logic [31:0] m_axi_rdata = '0;

   dma_cfg_sequencer #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   always #5 ACLK = ~ACLK;

   int unsigned checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave configuration
   int unsigned aw_lat = 0, w_lat = 0, ar_lat = 0, aw_stall_from = 99;
   int unsigned done_on = 1, rerr_on = 0;
   logic [31:0] berr_addr = 32'hFFFF_FFFF;

   // Handshakes seen at the last rising edge (pre-edge values)
   logic        s_cmd_hs = 0, s_aw_hs = 0, s_w_hs = 0, s_b_hs = 0, s_ar_hs = 0, s_r_hs = 0;
   logic        s_awv = 0, s_wv = 0, s_arv = 0;
   logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_src = '0, s_dst = '0, s_len = '0;

   always @(posedge ACLK) begin
      s_cmd_hs = cmd_valid & cmd_ready;
      s_aw_hs  = m_axi_awvalid & m_axi_awready;
      s_w_hs   = m_axi_wvalid & m_axi_wready;
      s_b_hs   = m_axi_bvalid & m_axi_bready;
      s_ar_hs  = m_axi_arvalid & m_axi_arready;
      s_r_hs   = m_axi_rvalid & m_axi_rready;
      s_awv    = m_axi_awvalid;
      s_wv     = m_axi_wvalid;
      s_arv    = m_axi_arvalid;
      s_awaddr = m_axi_awaddr;
      s_wdata  = m_axi_wdata;
      s_araddr = m_axi_araddr;
      s_src    = cmd_src;
      s_dst    = cmd_dst;
      s_len    = cmd_len;
   end

   // Transaction-level model state
   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t         exp_wr[$];
   wr_t         e;
   logic        exp_active = 0, exp_err = 0, fin_now = 0, fin_ok = 0;
   logic [1:0]  exp_code = '0;
   int unsigned fin_count = 0, n_writes = 0, n_reads = 0;
   logic        aw_got = 0, w_got = 0, b_pending = 0, r_pending = 0;
   logic [31:0] got_addr = '0, got_data = '0;
   int unsigned aw_cnt = 0, w_cnt = 0, ar_cnt = 0, lat = 0;

   task automatic terminate(input logic ok, input logic [1:0] code);
      exp_active = 0;
      fin_now    = 1;
      fin_ok     = ok;
      if (!ok) begin
         exp_err  = 1;
         exp_code = code;
      end
      fin_count++;
      exp_wr.delete();
   endtask

   // Slave responder and per-cycle comparison against the model
   initial begin : responder
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
            m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rdata = '0;
            exp_active = 0; exp_err = 0; exp_code = '0; fin_now = 0;
            aw_got = 0; w_got = 0; b_pending = 0; r_pending = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; n_writes = 0; n_reads = 0;
            exp_wr.delete();
            continue;
         end
         fin_now = 0;
         if (s_cmd_hs) begin
            exp_active = 1; exp_err = 0; exp_code = '0; n_writes = 0; n_reads = 0;
            exp_wr.delete();
            exp_wr.push_back('{BASE,              s_src});
            exp_wr.push_back('{BASE + 32'h4,      s_dst});
            exp_wr.push_back('{BASE + 32'h8,      s_len});
            exp_wr.push_back('{BASE + 32'hC,      32'h1});
         end
         if (s_b_hs) begin
            m_axi_bvalid = 0; b_pending = 0;
            if (m_axi_bresp != 2'b00) terminate(1'b0, 2'b01);
         end
         if (s_r_hs) begin
            m_axi_rvalid = 0; r_pending = 0;
            if (m_axi_rresp != 2'b00) terminate(1'b0, 2'b10);
            else if (m_axi_rdata[0]) terminate(1'b1, 2'b00);
`ifdef DMA_SEQ_TIMEOUT_EN
            else if (n_reads >= TMO) terminate(1'b0, 2'b11);
`endif
         end
         if (s_ar_hs) begin
            chk("araddr", s_araddr, BASE + 32'hC);
            m_axi_arready = 0; ar_cnt = 0;
            n_reads++;
            m_axi_rvalid = 1; r_pending = 1;
            m_axi_rdata = 32'hFFFF_FFFE | 32'((done_on != 0) && (n_reads >= done_on));
            m_axi_rresp = (n_reads == rerr_on) ? 2'b11 : 2'b00;
         end
         if (s_aw_hs) begin aw_got = 1; got_addr = s_awaddr; m_axi_awready = 0; aw_cnt = 0; end
         if (s_w_hs)  begin w_got = 1;  got_data = s_wdata;  m_axi_wready = 0;  w_cnt = 0;  end
         if (aw_got && w_got) begin
            n_writes++;
            if (exp_wr.size() == 0) chk("write_count", n_writes, 4);
            else begin
               e = exp_wr.pop_front();
               chk("write_addr", got_addr, e.addr);
               chk("write_data", got_data, e.data);
            end
            m_axi_bvalid = 1; b_pending = 1;
            m_axi_bresp = (got_addr == berr_addr) ? 2'b10 : 2'b00;
            aw_got = 0; w_got = 0;
         end
         if (m_axi_awvalid && !m_axi_awready) begin
            lat = (n_writes >= aw_stall_from) ? 1000 : aw_lat;
            if (aw_cnt >= lat) m_axi_awready = 1; else aw_cnt++;
         end
         if (m_axi_wvalid && !m_axi_wready) begin
            if (w_cnt >= w_lat) m_axi_wready = 1; else w_cnt++;
         end
         if (m_axi_arvalid && !m_axi_arready) begin
            if (ar_cnt >= ar_lat) m_axi_arready = 1; else ar_cnt++;
         end

         chk("busy", 32'(busy), 32'(exp_active));
         chk("cmd_ready", 32'(cmd_ready), 32'(!exp_active && !fin_now));
         chk("done", 32'(done), 32'(fin_now && fin_ok));
         chk("err", 32'(err), 32'(exp_err));
         chk("err_code", 32'(err_code), 32'(exp_code));
         chk("prot", 32'({m_axi_awprot, m_axi_arprot}), 32'h0);
         chk("wstrb", 32'(m_axi_wstrb), 32'hF);
         if (s_awv && !s_aw_hs) begin
            chk("awvalid_hold", 32'(m_axi_awvalid), 32'h1);
            chk("awaddr_stable", m_axi_awaddr, s_awaddr);
         end
         if (s_wv && !s_w_hs) begin
            chk("wvalid_hold", 32'(m_axi_wvalid), 32'h1);
            chk("wdata_stable", m_axi_wdata, s_wdata);
         end
         if (s_arv && !s_ar_hs) begin
            chk("arvalid_hold", 32'(m_axi_arvalid), 32'h1);
            chk("araddr_stable", m_axi_araddr, s_araddr);
         end
         if (s_aw_hs) chk("awvalid_drop", 32'(m_axi_awvalid), 32'h0);
         if (s_w_hs)  chk("wvalid_drop", 32'(m_axi_wvalid), 32'h0);
         if (s_ar_hs) chk("arvalid_drop", 32'(m_axi_arvalid), 32'h0);
         if (m_axi_bready) chk("bready_before_accept", 32'(b_pending), 32'h1);
         if (m_axi_rready) chk("rready_before_accept", 32'(r_pending), 32'h1);
         chk("wr_rd_overlap", 32'((m_axi_awvalid | m_axi_wvalid | m_axi_bready) &
                                  (m_axi_arvalid | m_axi_rready)), 32'h0);
         if (!exp_active)
            chk("idle_bus_quiet", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                       m_axi_arvalid, m_axi_rready}), 32'h0);
      end
   end

   task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
      @(negedge ACLK);
      cmd_valid = 1; cmd_src = s; cmd_dst = d; cmd_len = l;
      @(negedge ACLK);
      cmd_valid = 0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
   endtask

   task automatic wait_fin(input int unsigned target, input string name);
      int unsigned n = 0;
      while (fin_count < target && n < 2000) begin
         @(negedge ACLK);
         n++;
      end
      chk({name, "_completed"}, fin_count, target);
      repeat (2) @(negedge ACLK);
   endtask

   task automatic pulse_reset();
      @(negedge ACLK);
      ARESETN = 0;
      repeat (2) @(negedge ACLK);
      ARESETN = 1;
      @(negedge ACLK);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int unsigned f0;
      int unsigned n;
      repeat (3) @(negedge ACLK);
      ARESETN = 1;
      @(negedge ACLK);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'({err, err_code, done}), 32'h0);
      chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'h0);
      chk("rst_addr_data", m_axi_awaddr | m_axi_wdata | m_axi_araddr, 32'h0);

      // 1: zero-wait slave, DONE on third STATUS read
      done_on = 3;
      f0 = fin_count;
      run_cmd(32'h1000, 32'h2000, 32'h40);
      wait_fin(f0 + 1, "t1");
      chk("t1_writes", n_writes, 4);
      chk("t1_reads", n_reads, 3);
      chk("t1_idle", 32'({cmd_ready, busy, done}), 32'b100);

      // 2: AW accepted well before W, then the reverse; stray cmd_valid while busy
      done_on = 1; aw_lat = 0; w_lat = 3;
      f0 = fin_count;
      run_cmd(32'hA0, 32'hB0, 32'h100);
      repeat (3) @(negedge ACLK);
      cmd_valid = 1; cmd_src = 32'hDEAD;
      repeat (3) @(negedge ACLK);
      cmd_valid = 0; cmd_src = '0;
      wait_fin(f0 + 1, "t2a");
      chk("t2a_writes", n_writes, 4);
      aw_lat = 3; w_lat = 0;
      f0 = fin_count;
      run_cmd(32'hC0, 32'hD0, 32'h8);
      wait_fin(f0 + 1, "t2b");
      chk("t2b_writes", n_writes, 4);
      chk("t2b_reads", n_reads, 1);

      // 3: SLVERR on LEN write
      aw_lat = 0; w_lat = 0; berr_addr = BASE + 32'h8;
      f0 = fin_count;
      run_cmd(32'h1, 32'h2, 32'h3);
      wait_fin(f0 + 1, "t3");
      berr_addr = 32'hFFFF_FFFF;
      chk("t3_writes", n_writes, 3);
      chk("t3_reads", n_reads, 0);
      chk("t3_err", 32'({err, err_code}), 32'b101);

      // 4: DECERR on first poll; new command clears err
      rerr_on = 1;
      f0 = fin_count;
      run_cmd(32'h11, 32'h22, 32'h33);
      chk("t4_err_cleared", 32'(err), 32'h0);
      wait_fin(f0 + 1, "t4");
      rerr_on = 0;
      chk("t4_reads", n_reads, 1);
      chk("t4_err", 32'({err, err_code}), 32'b110);
      chk("t4_arvalid", 32'(m_axi_arvalid), 32'h0);

      // 5: DONE never set
      done_on = 0;
      f0 = fin_count;
      run_cmd(32'h5, 32'h6, 32'h7);
`ifdef DMA_SEQ_TIMEOUT_EN
      wait_fin(f0 + 1, "t5");
      chk("t5_reads", n_reads, TMO);
      chk("t5_err", 32'({err, err_code}), 32'b111);
`else
      n = 0;
      while (n_reads < 100 && n < 3000) begin
         @(negedge ACLK);
         n++;
      end
      chk("t5_reads_reached", 32'(n_reads >= 100), 32'h1);
      chk("t5_still_busy", 32'(busy), 32'h1);
      chk("t5_no_finish", fin_count, f0);
      pulse_reset();
`endif
      done_on = 1;

      // 6: reset while the DST write is stalled on awready
      aw_stall_from = 1;
      run_cmd(32'h77, 32'h88, 32'h99);
      n = 0;
      while (n_writes < 1 && n < 100) begin
         @(negedge ACLK);
         n++;
      end
      repeat (4) @(negedge ACLK);
      chk("t6_awvalid_before", 32'(m_axi_awvalid), 32'h1);
      chk("t6_awaddr_before", m_axi_awaddr, BASE + 32'h4);
      #2 ARESETN = 0;
      #1;
      chk("t6_valids_async", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'h0);
      chk("t6_busy_async", 32'({busy, cmd_ready}), 32'b01);
      aw_stall_from = 99;
      repeat (2) @(negedge ACLK);
      ARESETN = 1;
      @(negedge ACLK);
      chk("t6_after_release", 32'({cmd_ready, err, busy}), 32'b100);
      repeat (20) @(negedge ACLK);
      chk("t6_no_spurious_writes", n_writes, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
